// File: rtl/dmem_port_ctrl.sv
// rtl/dmem_port_ctrl.sv - byte-serial RAM port arbiter for Y86-64 fetch and memory stages
module dmem_port_ctrl #(
  parameter int MEM_BYTES = 1024,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [63:0]   i_addr,
  output logic          i_gnt,
  output logic          i_ack,
  output logic [79:0]   i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [63:0]   d_addr,
  input  logic [63:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_ack,
  output logic [63:0]   d_rdata,
  output logic          d_err,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);

  // Highest legal base per port; constants, so the compare cannot wrap.
  localparam logic [63:0] D_LIM = 64'(MEM_BYTES - 8);
  localparam logic [63:0] I_LIM = 64'(MEM_BYTES - 10);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nx;
  logic          sel_d, we_r, err_r, last_gnt;
  logic [AW-1:0] base_r;
  logic [63:0]   wdata_r;
  logic [3:0]    len_r, cnt;
  logic [79:0]   asm_r;
  logic [79:0]   i_rdata_q;
  logic [63:0]   d_rdata_q;
  logic          i_err_q, d_err_q;
  logic          pick_d, any_req, g_err;
  logic [3:0]    g_len;
  logic [AW-1:0] g_base;
  logic [79:0]   i_res;
  logic [63:0]   d_res;

  always_comb begin
    // last_gnt: 0 = fetch port, 1 = data port
    pick_d   = d_req & (~i_req | ~last_gnt);
    any_req  = i_req | d_req;
    g_err    = pick_d ? (d_addr > D_LIM) : (i_addr > I_LIM);
    g_len    = pick_d ? 4'd8 : 4'd10;
    g_base   = pick_d ? d_addr[AW-1:0] : i_addr[AW-1:0];
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = g_err ? DONE : XFER;
      XFER:    if (cnt == len_r - 4'd1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    i_gnt     = (state == IDLE) & i_req & ~pick_d & ~rst;
    d_gnt     = (state == IDLE) & pick_d & ~rst;
    i_ack     = (state == DONE) & ~sel_d;
    d_ack     = (state == DONE) & sel_d;
    busy      = (state != IDLE);
    ram_we    = (state == XFER) & we_r;
    ram_addr  = (state == XFER) ? base_r + AW'(cnt) : '0;
    ram_wdata = '0;
    if (state == XFER && we_r) begin
      for (int k = 0; k < 8; k++) begin
        if (cnt == 4'(k)) ram_wdata = wdata_r[8*k +: 8];
      end
    end
    i_res   = err_r ? 80'd0 : asm_r;
    d_res   = (err_r | we_r) ? 64'd0 : asm_r[63:0];
    // Fresh result during the ack cycle, held copy afterwards.
    i_rdata = i_ack ? i_res : i_rdata_q;
    i_err   = i_ack ? err_r : i_err_q;
    d_rdata = d_ack ? d_res : d_rdata_q;
    d_err   = d_ack ? err_r : d_err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_d     <= 1'b0;
      we_r      <= 1'b0;
      err_r     <= 1'b0;
      last_gnt  <= 1'b0;
      base_r    <= '0;
      wdata_r   <= '0;
      len_r     <= '0;
      cnt       <= '0;
      asm_r     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel_d   <= pick_d;
            we_r    <= pick_d & d_we;
            base_r  <= g_base;
            wdata_r <= d_wdata;
            len_r   <= g_len;
            err_r   <= g_err;
            cnt     <= '0;
            asm_r   <= '0;
          end
        end
        XFER: begin
          cnt <= cnt + 4'd1;
          if (!we_r) begin
            for (int k = 0; k < 10; k++) begin
              if (cnt == 4'(k)) asm_r[8*k +: 8] <= ram_rdata;
            end
          end
        end
        DONE: begin
          last_gnt <= sel_d;
          if (sel_d) begin
            d_rdata_q <= d_res;
            d_err_q   <= err_r;
          end else begin
            i_rdata_q <= i_res;
            i_err_q   <= err_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// tb/tb_dmem_port_ctrl.sv - directed and random checks of dmem_port_ctrl against a byte-array model
module tb_dmem_port_ctrl;

  localparam int MEM_BYTES = 1024;
  localparam int AW = 10;

  logic          clk, rst;
  logic          i_req, i_gnt, i_ack, i_err;
  logic [63:0]   i_addr;
  logic [79:0]   i_rdata;
  logic          d_req, d_we, d_gnt, d_ack, d_err;
  logic [63:0]   d_addr, d_wdata, d_rdata;
  logic          busy, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, ram_rdata;

  logic [7:0]    ram     [0:MEM_BYTES-1];
  logic [7:0]    ref_mem [0:MEM_BYTES-1];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [7:0]    pre_data;

  int total = 0;
  int bad = 0;

  dmem_port_ctrl #(.MEM_BYTES(MEM_BYTES), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .busy(busy), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign ram_rdata = ram[ram_addr];

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    else if (pre_we) ram[pre_addr] <= pre_data;
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] all_outs();
    return {i_gnt, i_ack, i_rdata, i_err, d_gnt, d_ack, d_rdata, d_err, busy, ram_addr, ram_we, ram_wdata};
  endfunction

  function automatic logic [79:0] model_rd(input int a, input int len);
    logic [79:0] r;
    r = '0;
    for (int k = 0; k < len; k++) r[8*k +: 8] = ref_mem[a + k];
    return r;
  endfunction

  task automatic preload(input int a, input logic [7:0] v);
    pre_we = 1'b1;
    pre_addr = AW'(a);
    pre_data = v;
    ref_mem[a] = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_outs", all_outs(), '0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_ack(input bit is_d, input int max, output int n);
    n = -1;
    for (int c = 1; c <= max; c++) begin
      @(negedge clk);
      if ((is_d ? d_ack : i_ack) === 1'b1) begin
        n = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Single uncontended access; called at posedge+1 with the controller idle.
  task automatic access(input bit is_d, input bit we, input logic [63:0] addr, input logic [63:0] wdata);
    int len, ack_c;
    bit exp_err;
    logic [79:0] exp_rd;
    logic [AW-1:0] eaddr;
    logic [7:0] ewd;
    len = is_d ? 8 : 10;
    exp_err = (addr >= 64'(MEM_BYTES)) || (addr + 64'(len) > 64'(MEM_BYTES));
    exp_rd = (!exp_err && !we) ? model_rd(int'(addr), len) : 80'd0;
    ack_c = exp_err ? 1 : len + 1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    @(negedge clk);
    chk("gnt", {(is_d ? d_gnt : i_gnt), (is_d ? i_gnt : d_gnt)}, 2'b10);
    @(posedge clk); #1;
    d_req = 1'b0;
    i_req = 1'b0;
    for (int c = 1; c < ack_c; c++) begin
      @(negedge clk);
      eaddr = AW'(addr + 64'(c - 1));
      ewd = we ? wdata[8*(c-1) +: 8] : 8'd0;
      chk("xfer", {i_ack, d_ack, busy, ram_we, ram_addr, ram_wdata}, {2'b00, 1'b1, we, eaddr, ewd});
      @(posedge clk); #1;
    end
    @(negedge clk);
    if (is_d)
      chk("d_ack", {d_ack, i_ack, d_err, d_rdata, ram_we, ram_addr},
          {1'b1, 1'b0, exp_err, (we ? 64'd0 : exp_rd[63:0]), 1'b0, {AW{1'b0}}});
    else
      chk("i_ack", {i_ack, d_ack, i_err, i_rdata, ram_we, ram_addr},
          {1'b1, 1'b0, exp_err, exp_rd, 1'b0, {AW{1'b0}}});
    @(posedge clk); #1;
    @(negedge clk);
    if (is_d)
      chk("d_hold", {busy, i_ack, d_ack, d_err, d_rdata}, {3'b000, exp_err, (we ? 64'd0 : exp_rd[63:0])});
    else
      chk("i_hold", {busy, i_ack, d_ack, i_err, i_rdata}, {3'b000, exp_err, exp_rd});
    @(posedge clk); #1;
    if (!exp_err && we)
      for (int k = 0; k < 8; k++) ref_mem[int'(addr) + k] = wdata[8*k +: 8];
  endtask

  initial begin
    int n, mism, choice, len;
    bit is_d, we;
    logic [63:0] a, w;
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    @(negedge clk);
    chk("reset_outs0", all_outs(), '0);
    @(posedge clk); #1;
    for (int i = 0; i < MEM_BYTES; i++) preload(i, 8'(i * 37 + 11));
    rst = 1'b0;

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle", {busy, ram_we, i_gnt, d_gnt, i_ack, d_ack}, 6'd0);
      @(posedge clk); #1;
    end

    access(1'b1, 1'b1, 64'd5, 64'h1122334455667788);
    access(1'b1, 1'b0, 64'd5, 64'd0);
    chk("d_read_const", d_rdata, 64'h1122334455667788);

    for (int k = 0; k < 10; k++) preload(30 + k, 8'(8'h30 + k));
    access(1'b0, 1'b0, 64'd30, 64'd0);
    chk("fetch_const", i_rdata, 80'h39383736353433323130);

    access(1'b1, 1'b0, 64'd1017, 64'd0);
    access(1'b1, 1'b0, 64'd1016, 64'd0);
    access(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'hDEADBEEFCAFEF00D);
    access(1'b1, 1'b1, 64'd1017, 64'hA5A5A5A5A5A5A5A5);
    access(1'b0, 1'b0, 64'd1014, 64'd0);
    access(1'b0, 1'b0, 64'd1015, 64'd0);
    access(1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd0);

    // Tie straight after reset: D, then I, then D again.
    do_reset();
    i_addr = 64'd200; d_addr = 64'd300; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    chk("tie1_gnt", {d_gnt, i_gnt}, 2'b10);
    @(posedge clk); #1;
    d_req = 1'b0;
    wait_ack(1'b1, 20, n);
    chk("tie1_d_lat", n, 9);
    chk("tie1_done_nogrant", {i_gnt, d_rdata}, {1'b0, model_rd(300, 8)});
    @(posedge clk); #1;
    @(negedge clk);
    chk("tie1_i_gnt", {i_gnt, d_gnt}, 2'b10);
    @(posedge clk); #1;
    i_req = 1'b0;
    wait_ack(1'b0, 20, n);
    chk("tie1_i_lat", n, 11);
    chk("tie1_i_data", {i_err, i_rdata}, {1'b0, model_rd(200, 10)});
    @(posedge clk); #1;
    i_addr = 64'd210; d_addr = 64'd310;
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    chk("tie2_gnt", {d_gnt, i_gnt}, 2'b10);
    @(posedge clk); #1;
    d_req = 1'b0;
    wait_ack(1'b1, 20, n);
    chk("tie2_d_lat", n, 9);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tie2_i_gnt", {i_gnt, d_gnt}, 2'b10);
    @(posedge clk); #1;
    i_req = 1'b0;
    wait_ack(1'b0, 20, n);
    chk("tie2_i_data", {i_rdata}, model_rd(210, 10));
    @(posedge clk); #1;

    // Reset during the fourth write cycle.
    for (int k = 0; k < 8; k++) preload(100 + k, 8'hEE);
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'd100; d_wdata = 64'h0102030405060708;
    @(negedge clk);
    chk("mw_gnt", d_gnt, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mw_reset_outs", all_outs(), '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mw_reset_outs2", all_outs(), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem[100] = 8'h08; ref_mem[101] = 8'h07; ref_mem[102] = 8'h06;
    for (int k = 0; k < 8; k++) chk($sformatf("mw_byte%0d", 100 + k), ram[100 + k], ref_mem[100 + k]);
    @(negedge clk);
    chk("mw_no_ack", {d_ack, busy}, 2'b00);
    @(posedge clk); #1;

    for (int t = 0; t < 40; t++) begin
      is_d = 1'($urandom % 2);
      we = is_d ? 1'($urandom % 2) : 1'b0;
      len = is_d ? 8 : 10;
      choice = int'($urandom % 8);
      if (choice == 0) a = 64'(MEM_BYTES - len) + 64'($urandom % 3);
      else if (choice == 1) a = 64'hFFFFFFFFFFFFFFF0 + 64'($urandom % 16);
      else a = 64'($urandom % (MEM_BYTES - len + 1));
      w = {$urandom, $urandom};
      access(is_d, we, a, w);
    end

    mism = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("ram_final", mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_ctrl.md
# dmem_port_ctrl

Sequencing and arbitration controller for the Y86-64 unified byte-wide data RAM. It serves two requesters: the fetch stage (10-byte read-only instruction fetch) and the memory stage (8-byte little-endian read or write for icodes 4, 5, 8, 9, 10, 11). It grants one requester at a time, serialises each access into per-byte RAM cycles, assembles or splits the data, and flags out-of-range accesses as `dmem_error`/`imem_error` before any RAM cycle is issued.

## Interface
- `MEM_BYTES`, 1024, RAM size in bytes; valid byte addresses are 0..MEM_BYTES-1
- `AW`, 10, RAM address width; must satisfy 2^AW >= MEM_BYTES
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `i_req` in 1: fetch request, level; held until `i_gnt`
- `i_addr` in 64: fetch byte address (PC)
- `i_gnt` out 1: fetch request accepted this cycle
- `i_ack` out 1: one-cycle fetch completion pulse
- `i_rdata` out 80: fetched bytes; byte k at bits [8k+7:8k]
- `i_err` out 1: `imem_error`, valid with `i_ack`
- `d_req` in 1: memory-stage request, level; held until `d_gnt`
- `d_we` in 1: 1 = write (`mem_write`), 0 = read (`mem_read`)
- `d_addr` in 64: data address (valE or valA)
- `d_wdata` in 64: write data (valA or valP), little-endian
- `d_gnt` out 1: data request accepted this cycle
- `d_ack` out 1: one-cycle data completion pulse
- `d_rdata` out 64: `valM`, valid with `d_ack`
- `d_err` out 1: `dmem_error`, valid with `d_ack`
- `busy` out 1: state is not IDLE
- `ram_addr` out AW: RAM byte address
- `ram_we` out 1: RAM byte write strobe
- `ram_wdata` out 8: RAM write byte
- `ram_rdata` in 8: RAM read byte, combinational from `ram_addr`

## Operation
- States: IDLE, XFER, DONE.
- IDLE: if exactly one `*_req` is high, grant it. If both are high, grant the port not granted last (round-robin on `last_gnt`). `*_gnt` is asserted combinationally in IDLE. The selected port's addr, we, and wdata are registered at the edge, together with len (10 for I, 8 for D) and `cnt`=0.
- Range check is done at the grant. The access errors if `addr > MEM_BYTES - len`. This is an unsigned 64-bit compare and must not overflow. On error, go to DONE with an error flag, skipping XFER. No RAM cycles are issued and no write occurs.
- XFER, for one cycle per byte k = `cnt`:
  - `ram_addr` = base+k, truncated to AW.
  - Write: `ram_we`=1 and `ram_wdata` = wdata[8k+7:8k].
  - Read: `ram_rdata` is captured into byte k of the assembly register.
  - `cnt` increments each cycle; after k = len-1, go to DONE.
- DONE: the granted port's `*_ack`=1 for one cycle and `*_err` = the error flag. On error `*_rdata` = 0. For a write, `d_rdata` = 0. `last_gnt` updates, then go to IDLE.
- `*_rdata` and `*_err` hold their value until the next `*_ack` of the same port.
- Outside XFER: `ram_we`=0, `ram_wdata`=0, `ram_addr`=0.
- A requester must not re-raise `*_req` until it has seen its `*_ack`. `*_req` while that port is busy is ignored.

## Timing
- Reset: state IDLE, `cnt`=0. Every output is 0, including both `*_rdata` and both `*_err`. `last_gnt`=I, so D wins the first tie.
- Reset mid-XFER aborts immediately: `ram_we` drops asynchronously and no ack is issued. Bytes already written stay in RAM.
- Gnt in cycle 0. XFER in cycles 1..len. Ack in cycle len+1. IDLE in cycle len+2, when the next grant can occur.
  - D access: ack in cycle 9.
  - I access: ack in cycle 11.
  - Error access: ack in cycle 1.
- Back-to-back: the minimum gap between grants is len+2 cycles.
- Simultaneous requests are served in alternating order. No port waits more than one foreign transaction.
- A request arriving during DONE waits for IDLE and is not granted in the DONE cycle.
- The last valid D address is MEM_BYTES-8 and the last valid I address is MEM_BYTES-10. Addresses near 2^64 must produce an error, not wrap.

## Test plan
- D write then read:
  - d_we=1, d_addr=5, d_wdata=0x1122334455667788 → `ram_we` is high in cycles 1-8 with addr 5..12 and bytes 0x88..0x11. `d_ack` in cycle 9 with `d_err`=0.
  - Read of addr 5 → `d_rdata`=0x1122334455667788.
- I fetch: preload bytes 30..39 with 0x30..0x39, then i_addr=30 → `i_ack` in cycle 11, `i_rdata`=0x39383736353433323130, `ram_we` never high.
- Errors:
  - d_addr=1017 with MEM_BYTES=1024 → `d_ack` in cycle 1 with `d_err`=1 and no RAM activity.
  - d_addr=1016 → `d_err`=0.
  - d_addr=0xFFFFFFFFFFFFFFFC → `d_err`=1.
- Tie after reset: `i_req` and `d_req` high in the same cycle → D is granted first. I is granted in the IDLE cycle after `d_ack`. A second tie then grants D again.
- Reset mid-write: assert `rst` in cycle 4 of a write to addr 100 → bytes 100-102 are written and bytes 103-107 are untouched. No `d_ack`; all outputs read 0 during reset.
- Idle behaviour: hold `*_req` low for 20 cycles → `busy`=0, `ram_we`=0, and no `*_gnt` or `*_ack` is asserted.
